// File: rtl/load_store_unit.sv
// Load/store unit: runs one data-memory transaction over a req/ack bus per accepted
// load/store, with legality check, lane steering, sign extension and bus timeout.
module load_store_unit #(
    parameter int TIMEOUT = 16
) (
    input  logic        clk,
    input  logic        rst,
    input  logic        ex_valid,
    input  logic [6:0]  opcode,
    input  logic [2:0]  funct3,
    input  logic [31:0] read_address,
    input  logic [31:0] write_address,
    input  logic [31:0] store_data,
    input  logic [4:0]  rd_in,
    input  logic [31:0] mem_rdata,
    input  logic        mem_ack,
    output logic [31:0] mem_addr,
    output logic [31:0] mem_wdata,
    output logic [3:0]  mem_byte_en,
    output logic        mem_read,
    output logic        mem_write,
    output logic [31:0] reg_write,
    output logic [4:0]  rd,
    output logic        writeEnable,
    output logic        done,
    output logic        fault,
    output logic        busy
);

    localparam logic [6:0] OP_LOAD  = 7'b0000011;
    localparam logic [6:0] OP_STORE = 7'b0100011;
    localparam int CNT_W = $clog2(TIMEOUT);
    localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(TIMEOUT - 1);

    typedef enum logic [1:0] {IDLE, REQ, DONE, FAULT} state_t;

    state_t           state;
    logic [CNT_W-1:0] cnt;
    logic [1:0]       lane_q;
    logic [2:0]       funct3_q;
    logic [4:0]       rd_q;
    logic             load_q;

    logic        is_load;
    logic        is_store;
    logic        accept;
    logic [31:0] acc_addr;

    assign is_load  = (opcode == OP_LOAD);
    assign is_store = (opcode == OP_STORE);
    assign accept   = ex_valid && (is_load || is_store);
    assign acc_addr = is_load ? read_address : write_address;
    assign busy     = (state != IDLE);

    function automatic logic access_legal(input logic load, input logic [2:0] f3,
                                          input logic [1:0] lane);
        logic ok;
        case (f3)
            3'b000:  ok = 1'b1;
            3'b001:  ok = ~lane[0];
            3'b010:  ok = (lane == 2'b00);
            3'b100:  ok = load;
            3'b101:  ok = load & ~lane[0];
            default: ok = 1'b0;
        endcase
        return ok;
    endfunction

    function automatic logic [3:0] byte_enable(input logic [2:0] f3, input logic [1:0] lane);
        logic [3:0] be;
        case (f3[1:0])
            2'b00:   be = 4'b0001 << lane;
            2'b01:   be = 4'b0011 << lane;
            default: be = 4'b1111;
        endcase
        return be;
    endfunction

    function automatic logic [31:0] store_lanes(input logic [2:0] f3, input logic [31:0] d);
        logic [31:0] w;
        case (f3[1:0])
            2'b00:   w = {4{d[7:0]}};
            2'b01:   w = {2{d[15:0]}};
            default: w = d;
        endcase
        return w;
    endfunction

    // Shift the addressed lane down to bit 0, then extend according to size/sign.
    function automatic logic [31:0] extend_load(input logic [2:0] f3, input logic [1:0] lane,
                                                input logic [31:0] data);
        logic [31:0] sh;
        logic [31:0] r;
        sh = data >> {lane, 3'b000};
        case (f3)
            3'b000:  r = {{24{sh[7]}}, sh[7:0]};
            3'b001:  r = {{16{sh[15]}}, sh[15:0]};
            3'b100:  r = {24'd0, sh[7:0]};
            3'b101:  r = {16'd0, sh[15:0]};
            default: r = data;
        endcase
        return r;
    endfunction

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            state       <= IDLE;
            cnt         <= '0;
            lane_q      <= '0;
            funct3_q    <= '0;
            rd_q        <= '0;
            load_q      <= 1'b0;
            mem_addr    <= '0;
            mem_wdata   <= '0;
            mem_byte_en <= '0;
            mem_read    <= 1'b0;
            mem_write   <= 1'b0;
            reg_write   <= '0;
            rd          <= '0;
            writeEnable <= 1'b0;
            done        <= 1'b0;
            fault       <= 1'b0;
        end else begin
            done        <= 1'b0;
            fault       <= 1'b0;
            writeEnable <= 1'b0;
            case (state)
                IDLE: begin
                    if (accept) begin
                        lane_q   <= acc_addr[1:0];
                        funct3_q <= funct3;
                        rd_q     <= rd_in;
                        load_q   <= is_load;
                        cnt      <= '0;
                        if (access_legal(is_load, funct3, acc_addr[1:0])) begin
                            state       <= REQ;
                            mem_addr    <= {acc_addr[31:2], 2'b00};
                            mem_byte_en <= byte_enable(funct3, acc_addr[1:0]);
                            mem_wdata   <= store_lanes(funct3, store_data);
                            mem_read    <= is_load;
                            mem_write   <= is_store;
                        end else begin
                            state <= FAULT;
                            fault <= 1'b1;
                        end
                    end
                end
                REQ: begin
                    // An ack on the final timeout edge still completes the access.
                    if (mem_ack) begin
                        state     <= DONE;
                        mem_read  <= 1'b0;
                        mem_write <= 1'b0;
                        done      <= 1'b1;
                        if (load_q) begin
                            reg_write   <= extend_load(funct3_q, lane_q, mem_rdata);
                            rd          <= rd_q;
                            writeEnable <= (rd_q != 5'd0);
                        end
                    end else if (cnt == CNT_LAST) begin
                        state     <= FAULT;
                        fault     <= 1'b1;
                        mem_read  <= 1'b0;
                        mem_write <= 1'b0;
                    end else begin
                        cnt <= cnt + 1'b1;
                    end
                end
                DONE:    state <= IDLE;
                FAULT:   state <= IDLE;
                default: state <= IDLE;
            endcase
        end
    end

endmodule

// File: tb/tb_load_store_unit.sv
// Bench for load_store_unit: directed cases plus random accesses checked against a
// size/sign/alignment model computed with plain arithmetic.
module tb_load_store_unit;

    localparam int TIMEOUT = 16;

    logic        clk = 1'b0;
    logic        rst;
    logic        ex_valid;
    logic [6:0]  opcode;
    logic [2:0]  funct3;
    logic [31:0] read_address;
    logic [31:0] write_address;
    logic [31:0] store_data;
    logic [4:0]  rd_in;
    logic [31:0] mem_rdata;
    logic        mem_ack;
    logic [31:0] mem_addr;
    logic [31:0] mem_wdata;
    logic [3:0]  mem_byte_en;
    logic        mem_read;
    logic        mem_write;
    logic [31:0] reg_write;
    logic [4:0]  rd;
    logic        writeEnable;
    logic        done;
    logic        fault;
    logic        busy;

    int vectors = 0;
    int miscompares = 0;
    logic [31:0] last_rw = '0;
    logic [4:0]  last_rd = '0;

    load_store_unit #(.TIMEOUT(TIMEOUT)) dut (
        .clk(clk), .rst(rst), .ex_valid(ex_valid), .opcode(opcode), .funct3(funct3),
        .read_address(read_address), .write_address(write_address),
        .store_data(store_data), .rd_in(rd_in), .mem_rdata(mem_rdata), .mem_ack(mem_ack),
        .mem_addr(mem_addr), .mem_wdata(mem_wdata), .mem_byte_en(mem_byte_en),
        .mem_read(mem_read), .mem_write(mem_write), .reg_write(reg_write), .rd(rd),
        .writeEnable(writeEnable), .done(done), .fault(fault), .busy(busy)
    );

    always #5 clk = ~clk;

    initial begin
        #1000000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        vectors++;
        assert (obs === exp) else begin
            miscompares++;
            $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
        end
    endtask

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    // One access: ack_at is the REQ cycle index carrying mem_ack (>= TIMEOUT means never).
    task automatic run_op(input bit ld, input logic [2:0] f3, input logic [31:0] a,
                          input logic [31:0] d, input logic [4:0] r, input int ack_at,
                          input logic [31:0] rdat);
        bit ok;
        int lane;
        int sz;
        longint v;
        logic [3:0]  exp_be;
        logic [31:0] exp_wd;
        logic [31:0] exp_res;
        int k;

        lane = int'(a[1:0]);
        sz = 1 << f3[1:0];
        ok = ld ? (f3 inside {3'd0, 3'd1, 3'd2, 3'd4, 3'd5}) : (f3 <= 3'd2);
        if (ok && (lane % sz) != 0) ok = 1'b0;
        exp_be = (sz == 4) ? 4'hF : ((sz == 2 ? 4'h3 : 4'h1) << lane);
        exp_wd = (sz == 1) ? d[7:0] * 32'h01010101 : (sz == 2) ? d[15:0] * 32'h00010001 : d;
        v = longint'(rdat >> (8 * lane));
        if (sz < 4) begin
            v = v % (longint'(1) << (8 * sz));
            if (!f3[2] && v >= (longint'(1) << (8 * sz - 1))) v = v - (longint'(1) << (8 * sz));
        end
        exp_res = v[31:0];

        opcode        = ld ? 7'b0000011 : 7'b0100011;
        funct3        = f3;
        read_address  = ld ? a : $urandom;
        write_address = ld ? $urandom : a;
        store_data    = d;
        rd_in         = r;
        ex_valid      = 1'b1;
        step();
        ex_valid = 1'b0;
        check("busy_after_accept", busy, 1);

        if (!ok) begin
            check("illegal_fault", fault, 1);
            check("illegal_no_read", mem_read, 0);
            check("illegal_no_write", mem_write, 0);
            step();
            check("illegal_fault_clear", fault, 0);
            check("illegal_busy_clear", busy, 0);
            check("illegal_reg_keep", reg_write, last_rw);
            return;
        end

        for (k = 0; k < TIMEOUT; k++) begin
            check("req_read", mem_read, ld);
            check("req_write", mem_write, !ld);
            check("req_addr", mem_addr, a & 32'hFFFF_FFFC);
            check("req_no_fault", fault, 0);
            if (!ld) begin
                check("req_be", mem_byte_en, exp_be);
                check("req_wdata", mem_wdata, exp_wd);
            end
            // Junk on the inputs while busy must be ignored.
            ex_valid      = (k != ack_at);
            opcode        = 7'b0100011;
            funct3        = 3'($urandom_range(0, 7));
            write_address = $urandom;
            read_address  = $urandom;
            store_data    = $urandom;
            mem_ack       = (k == ack_at);
            mem_rdata     = (k == ack_at) ? rdat : $urandom;
            step();
            mem_ack = 1'b0;
            if (k == ack_at) break;
        end
        ex_valid = 1'b0;

        if (ack_at < TIMEOUT) begin
            if (ld) begin
                last_rw = exp_res;
                last_rd = r;
            end
            check("done_pulse", done, 1);
            check("done_we", writeEnable, ld && r != 5'd0);
            check("done_read_drop", mem_read, 0);
            check("done_write_drop", mem_write, 0);
            check("done_reg_write", reg_write, last_rw);
            check("done_rd", rd, last_rd);
            step();
            check("after_done", done, 0);
            check("after_we", writeEnable, 0);
            check("after_busy", busy, 0);
        end else begin
            check("timeout_fault", fault, 1);
            check("timeout_read_drop", mem_read, 0);
            check("timeout_write_drop", mem_write, 0);
            check("timeout_no_we", writeEnable, 0);
            check("timeout_no_done", done, 0);
            step();
            check("timeout_fault_clear", fault, 0);
            check("timeout_busy_clear", busy, 0);
            check("timeout_reg_keep", reg_write, last_rw);
        end
    endtask

    initial begin
        rst = 1'b0;
        ex_valid = 1'b0;
        opcode = '0;
        funct3 = '0;
        read_address = '0;
        write_address = '0;
        store_data = '0;
        rd_in = '0;
        mem_rdata = '0;
        mem_ack = 1'b0;
        repeat (2) step();
        check("rst_busy", busy, 0);
        check("rst_read", mem_read, 0);
        check("rst_write", mem_write, 0);
        check("rst_reg_write", reg_write, 0);
        check("rst_rd", rd, 0);
        check("rst_done", done, 0);
        check("rst_fault", fault, 0);
        check("rst_we", writeEnable, 0);
        rst = 1'b1;
        step();

        // Store word, ack in second REQ cycle.
        run_op(1'b0, 3'b010, 32'h0000_0100, 32'hDEAD_BEEF, 5'd3, 1, 32'h0);
        // LB / LBU from top lane.
        run_op(1'b1, 3'b000, 32'h0000_0103, 32'h0, 5'd5, 0, 32'h80FF_FF00);
        check("lb_const", reg_write, 32'hFFFF_FF80);
        run_op(1'b1, 3'b100, 32'h0000_0103, 32'h0, 5'd5, 0, 32'h80FF_FF00);
        check("lbu_const", reg_write, 32'h0000_0080);
        // Upper halfword store and signed halfword load.
        run_op(1'b0, 3'b001, 32'h0000_0202, 32'h0000_ABCD, 5'd1, 0, 32'h0);
        run_op(1'b1, 3'b001, 32'h0000_0202, 32'h0, 5'd7, 2, 32'h8001_0000);
        check("lh_const", reg_write, 32'hFFFF_8001);
        // Illegal accesses.
        run_op(1'b1, 3'b010, 32'h0000_0101, 32'h0, 5'd4, 0, 32'h0);
        run_op(1'b0, 3'b001, 32'h0000_0201, 32'h1234, 5'd4, 0, 32'h0);
        run_op(1'b1, 3'b011, 32'h0000_0200, 32'h0, 5'd4, 0, 32'h0);
        run_op(1'b0, 3'b100, 32'h0000_0200, 32'h0, 5'd4, 0, 32'h0);
        // Timeout, and ack on the last permitted edge.
        run_op(1'b1, 3'b010, 32'h0000_0400, 32'h0, 5'd6, TIMEOUT + 4, 32'h0);
        run_op(1'b1, 3'b010, 32'h0000_0404, 32'h0, 5'd6, TIMEOUT - 1, 32'h1357_9BDF);
        // Load into x0: done without a register write.
        run_op(1'b1, 3'b010, 32'h0000_0408, 32'h0, 5'd0, 0, 32'hCAFE_F00D);

        // Non-memory opcode is ignored.
        opcode = 7'b0110011;
        ex_valid = 1'b1;
        step();
        ex_valid = 1'b0;
        check("other_op_idle", busy, 0);
        check("other_op_no_read", mem_read, 0);

        // Asynchronous reset in the middle of a request.
        opcode = 7'b0000011;
        funct3 = 3'b010;
        read_address = 32'h0000_0300;
        rd_in = 5'd9;
        ex_valid = 1'b1;
        step();
        ex_valid = 1'b0;
        check("pre_reset_read", mem_read, 1);
        #3 rst = 1'b0;
        #1;
        check("async_rst_read", mem_read, 0);
        check("async_rst_busy", busy, 0);
        last_rw = '0;
        last_rd = '0;
        check("async_rst_reg", reg_write, 0);
        step();
        rst = 1'b1;
        step();

        for (int i = 0; i < 40; i++) begin
            bit ld;
            int ack;
            ld = 1'($urandom_range(0, 1));
            ack = ($urandom_range(0, 9) == 0) ? TIMEOUT + 2 : $urandom_range(0, 3);
            run_op(ld, 3'($urandom_range(0, 7)), $urandom, $urandom, 5'($urandom_range(0, 31)),
                   ack, $urandom);
        end

        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end

endmodule
